seg_scan_decoder: RTL and testbench

//  Receive-side counterpart of the multiplexed 7-segment driver: it watches the scanned AN/SEG

---
 rtl/seg_scan_decoder.sv | 225 ++++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Rebuilds the 16-bit hex value and decimal points from scanned, active-low AN/SEG display lines.
// Latency: 2 (sync) + SETTLE_CYC (stability) + 2 (capture, frame commit) clk from final digit to dat_vld.
// No backpressure: observe-only receiver; outputs are pulses/levels, nothing is held off.
module seg_scan_decoder #(
   parameter int SETTLE_CYC  = 16,     // must be >= 2
   parameter int TIMEOUT_CYC = 400000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  an,
   input  logic [7:0]  seg,
   output logic [15:0] dat,
   output logic [3:0]  dp,
   output logic        dat_vld,
   output logic        seg_err,
   output logic        an_err,
   output logic        stale
);

   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {
      ST_WAIT   = 2'd0,
      ST_STABLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   // Decoded pattern {g..a} (1 = lit) -> {match, nibble}
   function automatic logic [4:0] hex_dec(input logic [6:0] p);
      logic [4:0] r;
      case (p)
         7'h3F:   r = 5'h10;
         7'h06:   r = 5'h11;
         7'h5B:   r = 5'h12;
         7'h4F:   r = 5'h13;
         7'h66:   r = 5'h14;
         7'h6D:   r = 5'h15;
         7'h7D:   r = 5'h16;
         7'h07:   r = 5'h17;
         7'h7F:   r = 5'h18;
         7'h6F:   r = 5'h19;
         7'h77:   r = 5'h1A;
         7'h7C:   r = 5'h1B;
         7'h39:   r = 5'h1C;
         7'h5E:   r = 5'h1D;
         7'h79:   r = 5'h1E;
         7'h71:   r = 5'h1F;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   logic [3:0]    an_s1_q, an_s2_q;
   logic [7:0]    seg_s1_q, seg_s2_q;
   logic [11:0]   cur;

   state_t        state_q, state_d;
   logic [11:0]   prev_q, prev_d;
   logic [11:0]   smp_q, smp_d;
   logic [SW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [3:0]    mask_q, mask_d;
   logic [15:0]   shd_dat_q, shd_dat_d;
   logic [3:0]    shd_dp_q, shd_dp_d;
   logic [15:0]   dat_q, dat_d;
   logic [3:0]    dp_q, dp_d;
   logic          dat_vld_q, dat_vld_d;
   logic          seg_err_q, seg_err_d;
   logic          an_err_q, an_err_d;
   logic          stale_q, stale_d;

   logic [3:0]    an_low;
   logic [4:0]    dec;
   logic          cap;

   // Two-flop synchronizer on the raw display lines
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_s1_q  <= '0;
         an_s2_q  <= '0;
         seg_s1_q <= '0;
         seg_s2_q <= '0;
      end else begin
         an_s1_q  <= an;
         an_s2_q  <= an_s1_q;
         seg_s1_q <= seg;
         seg_s2_q <= seg_s1_q;
      end
   end

   assign cur    = {an_s2_q, seg_s2_q};
   assign an_low = ~smp_q[11:8];
   assign dec    = hex_dec(~smp_q[6:0]);

   // Next-state: settle tracking, digit capture, frame commit and staleness timeout
   always_comb begin
      state_d   = state_q;
      prev_d    = cur;
      smp_d     = smp_q;
      cnt_d     = cnt_q;
      to_cnt_d  = to_cnt_q;
      mask_d    = mask_q;
      shd_dat_d = shd_dat_q;
      shd_dp_d  = shd_dp_q;
      dat_d     = dat_q;
      dp_d      = dp_q;
      dat_vld_d = 1'b0;
      seg_err_d = 1'b0;
      an_err_d  = 1'b0;
      stale_d   = stale_q;
      cap       = 1'b0;

      // Commit the frame the cycle after all four slots are filled
      if (mask_q == 4'hF) begin
         dat_d     = shd_dat_q;
         dp_d      = shd_dp_q;
         dat_vld_d = 1'b1;
         mask_d    = 4'h0;
         stale_d   = 1'b0;
      end

      case (state_q)
         ST_WAIT: begin
            if (cur != prev_q) begin
               state_d = ST_STABLE;
               cnt_d   = SW'(1);
            end
         end
         ST_STABLE: begin
            if (cur != prev_q) begin
               cnt_d = SW'(1);
            end else if (cnt_q == SW'(SETTLE_CYC - 1)) begin
               // cur has now held for SETTLE_CYC consecutive cycles
               state_d = ST_SAMPLE;
               smp_d   = cur;
            end else begin
               cnt_d = cnt_q + SW'(1);
            end
         end
         ST_SAMPLE: begin
            state_d = ST_HOLD;
            if (an_low == 4'h0) begin
               // blank period between digits: nothing to record
            end else if (!$onehot(an_low)) begin
               an_err_d = 1'b1;
            end else if (dec[4]) begin
               cap = 1'b1;
               for (int i = 0; i < 4; i++) begin
                  if (an_low[i]) begin
                     shd_dat_d[4*i +: 4] = dec[3:0];
                     shd_dp_d[i]         = ~smp_q[7];
                     mask_d[i]           = 1'b1;
                  end
               end
            end else begin
               seg_err_d = 1'b1;
               mask_d    = mask_d & ~an_low;
            end
         end
         ST_HOLD: begin
            // Compare against the sampled value so a change landing in SAMPLE is not missed
            if (cur != smp_q) begin
               state_d = ST_STABLE;
               cnt_d   = SW'(1);
            end
         end
         default: state_d = ST_WAIT;
      endcase

      // A capture in the same cycle as the timeout wins
      if (cap) begin
         to_cnt_d = '0;
      end else if (to_cnt_q != TW'(TIMEOUT_CYC)) begin
         to_cnt_d = to_cnt_q + TW'(1);
      end else begin
         stale_d = 1'b1;
         mask_d  = 4'h0;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_WAIT;
         prev_q    <= '0;
         smp_q     <= '0;
         cnt_q     <= '0;
         to_cnt_q  <= '0;
         mask_q    <= '0;
         shd_dat_q <= '0;
         shd_dp_q  <= '0;
         dat_q     <= '0;
         dp_q      <= '0;
         dat_vld_q <= 1'b0;
         seg_err_q <= 1'b0;
         an_err_q  <= 1'b0;
         stale_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         prev_q    <= prev_d;
         smp_q     <= smp_d;
         cnt_q     <= cnt_d;
         to_cnt_q  <= to_cnt_d;
         mask_q    <= mask_d;
         shd_dat_q <= shd_dat_d;
         shd_dp_q  <= shd_dp_d;
         dat_q     <= dat_d;
         dp_q      <= dp_d;
         dat_vld_q <= dat_vld_d;
         seg_err_q <= seg_err_d;
         an_err_q  <= an_err_d;
         stale_q   <= stale_d;
      end
   end

   assign dat     = dat_q;
   assign dp      = dp_q;
   assign dat_vld = dat_vld_q;
   assign seg_err = seg_err_q;
   assign an_err  = an_err_q;
   assign stale   = stale_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans hex frames onto an/seg and checks the rebuilt outputs.
// Short settle/timeout parameters keep the run small; digits dwell DWELL cycles each.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_seg_scan_decoder;

   localparam int SETTLE = 16;
   localparam int TMO    = 1000;
   localparam int DWELL  = 40;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  an;
   logic [7:0]  seg;
   logic [15:0] dat;
   logic [3:0]  dp;
   logic        dat_vld;
   logic        seg_err;
   logic        an_err;
   logic        stale;

   seg_scan_decoder #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .an      (an),
      .seg     (seg),
      .dat     (dat),
      .dp      (dp),
      .dat_vld (dat_vld),
      .seg_err (seg_err),
      .an_err  (an_err),
      .stale   (stale)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Segment patterns {g..a}, 1 = lit
   logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   int n_chk = 0;
   int n_err = 0;
   int vld_cnt = 0, serr_cnt = 0, aerr_cnt = 0;
   int vld_cyc = 0, drv_cyc = 0;

   // Pulse counters
   always @(negedge clk) begin
      if (dat_vld === 1'b1) begin
         vld_cnt = vld_cnt + 1;
         vld_cyc = cyc;
      end
      if (seg_err === 1'b1) serr_cnt = serr_cnt + 1;
      if (an_err === 1'b1)  aerr_cnt = aerr_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Show one digit for 'cycles' cycles; called and returns on a falling edge
   task automatic show(input int idx, input logic [3:0] nib, input logic dpl, input int cycles);
      an  = ~(4'(1) << idx);
      seg = {~dpl, ~hex_tab[nib]};
      if (idx == 3) drv_cyc = cyc;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic scan(input logic [15:0] v, input logic [3:0] dps);
      for (int i = 0; i < 4; i++) show(i, v[4*i +: 4], dps[i], DWELL);
   endtask

   int v0, s0, a0, target;
   logic [7:0] good_seg;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      an    = 4'hF;
      seg   = 8'hFF;
      repeat (3) @(negedge clk);
      chk("rst_dat", 32'(dat), 32'h0);
      chk("rst_dp", 32'(dp), 32'h0);
      chk("rst_vld", 32'(dat_vld), 32'h0);
      chk("rst_seg_err", 32'(seg_err), 32'h0);
      chk("rst_an_err", 32'(an_err), 32'h0);
      chk("rst_stale", 32'(stale), 32'h1);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: two frames of 1A2F
      v0 = vld_cnt;
      scan(16'h1A2F, 4'b0000);
      chk("t1_latency", 32'(vld_cyc - drv_cyc), 32'(2 + SETTLE + 2));
      chk("t1_dat_f1", 32'(dat), 32'h1A2F);
      scan(16'h1A2F, 4'b0000);
      chk("t1_vld_cnt", 32'(vld_cnt - v0), 32'd2);
      chk("t1_dat", 32'(dat), 32'h1A2F);
      chk("t1_dp", 32'(dp), 32'h0);
      chk("t1_stale", 32'(stale), 32'h0);

      // 2: 8888 with dp on digit 2
      v0 = vld_cnt;
      scan(16'h8888, 4'b0100);
      chk("t2_vld_cnt", 32'(vld_cnt - v0), 32'd1);
      chk("t2_dat", 32'(dat), 32'h8888);
      chk("t2_dp", 32'(dp), 32'h4);

      // 3: digit 1 glitched every 8 cycles, then clean digit 1
      v0 = vld_cnt;
      show(0, 4'hE, 1'b0, DWELL);
      good_seg = {1'b1, ~hex_tab[5]};
      an = 4'b1101;
      for (int c = 0; c < DWELL; c++) begin
         seg = ((c % 8) == 0 && c > 0) ? (good_seg ^ 8'h01) : good_seg;
         @(negedge clk);
      end
      show(2, 4'hC, 1'b0, DWELL);
      show(3, 4'h3, 1'b0, DWELL);
      chk("t3_no_vld_glitch", 32'(vld_cnt - v0), 32'd0);
      chk("t3_dat_held", 32'(dat), 32'h8888);
      show(0, 4'hE, 1'b0, DWELL);
      show(1, 4'h5, 1'b0, DWELL);
      chk("t3_vld_clean", 32'(vld_cnt - v0), 32'd1);
      chk("t3_dat", 32'(dat), 32'h3C5E);

      // 4: invalid pattern on digit 3 for two frames, then fixed
      v0 = vld_cnt;
      s0 = serr_cnt;
      for (int f = 0; f < 2; f++) begin
         show(0, 4'hD, 1'b0, DWELL);
         show(1, 4'h6, 1'b0, DWELL);
         show(2, 4'hB, 1'b0, DWELL);
         an  = 4'b0111;
         seg = {1'b1, ~7'h7E};
         repeat (DWELL) @(negedge clk);
      end
      chk("t4_seg_err_cnt", 32'(serr_cnt - s0), 32'd2);
      chk("t4_no_vld", 32'(vld_cnt - v0), 32'd0);
      scan(16'h4B6D, 4'b0000);
      chk("t4_vld_resume", 32'(vld_cnt - v0), 32'd1);
      chk("t4_dat", 32'(dat), 32'h4B6D);
      chk("t4_seg_err_after", 32'(serr_cnt - s0), 32'd2);

      // 5: two digits selected, then blank
      a0 = aerr_cnt;
      s0 = serr_cnt;
      v0 = vld_cnt;
      an  = 4'b1100;
      seg = 8'hC0;
      repeat (200) @(negedge clk);
      chk("t5_an_err_once", 32'(aerr_cnt - a0), 32'd1);
      an  = 4'b1111;
      seg = 8'hFF;
      repeat (200) @(negedge clk);
      chk("t5_blank_an_err", 32'(aerr_cnt - a0), 32'd1);
      chk("t5_blank_seg_err", 32'(serr_cnt - s0), 32'd0);
      chk("t5_blank_vld", 32'(vld_cnt - v0), 32'd0);

      // 6: stop scanning after a good frame -> stale after timeout, data held
      v0 = vld_cnt;
      scan(16'h5E07, 4'b1000);
      an  = 4'hF;
      seg = 8'hFF;
      chk("t6_vld", 32'(vld_cnt - v0), 32'd1);
      chk("t6_stale_low", 32'(stale), 32'h0);
      target = vld_cyc + TMO - 1;
      while (cyc < target) @(negedge clk);
      chk("t6_stale_before", 32'(stale), 32'h0);
      @(negedge clk);
      chk("t6_stale_at_tmo", 32'(stale), 32'h1);
      chk("t6_dat_held", 32'(dat), 32'h5E07);
      chk("t6_dp_held", 32'(dp), 32'h8);

      // Reset mid-frame: outputs back to reset values, partial frame dropped
      v0 = vld_cnt;
      show(0, 4'h9, 1'b0, DWELL);
      show(1, 4'h9, 1'b0, DWELL);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_dat", 32'(dat), 32'h0);
      chk("t6_rst_dp", 32'(dp), 32'h0);
      chk("t6_rst_stale", 32'(stale), 32'h1);
      chk("t6_rst_flags", 32'({dat_vld, seg_err, an_err}), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      show(2, 4'h9, 1'b0, DWELL);
      show(3, 4'h9, 1'b0, DWELL);
      chk("t6_partial_dropped", 32'(vld_cnt - v0), 32'd0);
      chk("t6_dat_after_rst", 32'(dat), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
